// File: rtl/duty_step_sequencer_pkg.sv
// ---------------------------------------------------------------------------
// pwm_pkg
// Shared definitions for the duty step sequencer that drives the PWM
// generator's increase_duty / decrease_duty inputs.
//   DUTY_W        duty width, matches the PWM generator counter
//   HOME_DUTY     generator power-up duty, also the shadow duty after reset
//   DUTY_MAX      highest duty that may ever be requested
//   STEP_HIGH_CYC cycles each step pulse is held high
//   STEP_LOW_CYC  low cycles after each step pulse
//   HOLD_CYC      dwell at target before the automatic return
//   seq_state_t   sequencer state encoding
//   step_dir_t    direction of a single duty step
// ---------------------------------------------------------------------------
package pwm_pkg;

    localparam int DUTY_W        = 5;
    localparam int HOME_DUTY     = 5;
    localparam int DUTY_MAX      = 31;
    localparam int STEP_HIGH_CYC = 4;
    localparam int STEP_LOW_CYC  = 4;
    localparam int HOLD_CYC      = 16;

    typedef enum logic [2:0] {
        S_IDLE,
        S_PULSE,
        S_GAP,
        S_HOLD,
        S_RETURN_PULSE,
        S_RETURN_GAP,
        S_FINISH
    } seq_state_t;

    typedef enum logic [1:0] {
        DIR_NONE,
        DIR_UP,
        DIR_DOWN
    } step_dir_t;

    // Largest of three cycle counts; sizes the shared phase timer.
    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/duty_step_sequencer_step_pulse_timer.sv
// ---------------------------------------------------------------------------
// step_pulse_timer
// Loadable down-counter shared by all timed sequencer phases. Loading N-1
// makes phase_last assert on the N-th cycle of the phase.
//   clk        system clock
//   reset      asynchronous, active-high reset
//   load       load load_val this cycle (takes priority over counting)
//   load_val   phase length minus one
//   phase_last high during the final cycle of the current phase
// ---------------------------------------------------------------------------
module step_pulse_timer #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    output logic             phase_last
);

    logic [CNT_W-1:0] count_reg;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_reg <= '0;
        end else if (load) begin
            count_reg <= load_val;
        end else if (count_reg != '0) begin
            count_reg <= count_reg - 1'b1;
        end
    end

    assign phase_last = (count_reg == '0);

endmodule

// File: rtl/duty_step_sequencer.sv
// ---------------------------------------------------------------------------
// duty_step_sequencer
// Accepts a target duty over a valid/ready handshake and walks the PWM
// generator duty to it, one spaced increase/decrease pulse per unit step,
// slow enough for the generator's debouncer to see every pulse exactly once.
// Keeps a shadow copy of the generator duty in cur_duty.
//
// Optional feature: define DISPENSE_AUTO_RETURN_EN to dwell HOLD_CYC cycles
// at the target and then step back to HOME_DUTY before signalling done.
//
// Ports
//   clk            system clock
//   reset          asynchronous, active-high reset
//   req_valid      new target duty offered
//   req_duty       target duty, sampled when req_valid & req_ready
//   req_ready      high only while idle
//   increase_duty  registered step-up pulse to the PWM generator
//   decrease_duty  registered step-down pulse to the PWM generator
//   cur_duty       shadow of the generator duty
//   busy           high in every state except idle
//   done           one-cycle pulse when the sequence completes
// ---------------------------------------------------------------------------
module duty_step_sequencer
    import pwm_pkg::*;
#(
    parameter int DW       = DUTY_W,
    parameter int HOME     = HOME_DUTY,
    parameter int DMAX     = DUTY_MAX,
    parameter int HIGH_CYC = STEP_HIGH_CYC,
    parameter int LOW_CYC  = STEP_LOW_CYC,
    parameter int DWELL    = HOLD_CYC
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          req_valid,
    input  logic [DW-1:0] req_duty,
    output logic          req_ready,
    output logic          increase_duty,
    output logic          decrease_duty,
    output logic [DW-1:0] cur_duty,
    output logic          busy,
    output logic          done
);

    localparam int TMR_W = $clog2(max3(HIGH_CYC, LOW_CYC, DWELL) + 1);

    localparam logic [TMR_W-1:0] HIGH_LOAD = TMR_W'(HIGH_CYC - 1);
    localparam logic [TMR_W-1:0] LOW_LOAD  = TMR_W'(LOW_CYC - 1);
    localparam logic [TMR_W-1:0] HOLD_LOAD = TMR_W'(DWELL - 1);
    localparam logic [DW-1:0]    HOME_VAL  = DW'(HOME);
    localparam logic [DW-1:0]    MAX_VAL   = DW'(DMAX);

    seq_state_t       state_reg;
    logic [DW-1:0]    tgt_reg;
    logic [DW-1:0]    cur_duty_reg;
    logic             inc_reg;
    logic             dec_reg;
    logic             done_reg;
    logic             ready_reg;
    logic             busy_reg;

    logic [DW-1:0]    req_clamped;
    logic             accept;
    logic             tmr_load;
    logic [TMR_W-1:0] tmr_val;
    logic             phase_last;
    step_dir_t        dir_tgt;
    step_dir_t        dir_home;

    assign req_clamped = (req_duty > MAX_VAL) ? MAX_VAL : req_duty;
    assign accept      = req_valid && ready_reg;

    // Direction of the next step towards the latched target or towards home.
    assign dir_tgt  = (tgt_reg > cur_duty_reg)  ? DIR_UP :
                      (tgt_reg < cur_duty_reg)  ? DIR_DOWN : DIR_NONE;
    assign dir_home = (HOME_VAL > cur_duty_reg) ? DIR_UP :
                      (HOME_VAL < cur_duty_reg) ? DIR_DOWN : DIR_NONE;

    // Apply the step of the pulse that is just ending. The bounds guard
    // keeps the shadow from wrapping even if the direction were wrong.
    function automatic logic [DW-1:0] stepped(input logic [DW-1:0] cur,
                                              input logic up,
                                              input logic down);
        logic [DW-1:0] nxt;
        nxt = cur;
        if (up && (cur < MAX_VAL)) begin
            nxt = cur + 1'b1;
        end else if (down && (cur != '0)) begin
            nxt = cur - 1'b1;
        end
        return nxt;
    endfunction

    // The timer reloads on every phase boundary; the load value is the
    // length of the phase being entered. Reloading on the way to FINISH is
    // harmless because FINISH is untimed.
    always_comb begin
        tmr_load = 1'b0;
        tmr_val  = HIGH_LOAD;
        case (state_reg)
            S_IDLE: begin
                tmr_load = accept;
`ifdef DISPENSE_AUTO_RETURN_EN
                tmr_val  = (req_clamped == cur_duty_reg) ? HOLD_LOAD : HIGH_LOAD;
`else
                tmr_val  = HIGH_LOAD;
`endif
            end
            S_PULSE, S_RETURN_PULSE: begin
                tmr_load = phase_last;
                tmr_val  = LOW_LOAD;
            end
            S_GAP: begin
                tmr_load = phase_last;
`ifdef DISPENSE_AUTO_RETURN_EN
                tmr_val  = (cur_duty_reg != tgt_reg) ? HIGH_LOAD : HOLD_LOAD;
`else
                tmr_val  = HIGH_LOAD;
`endif
            end
            S_HOLD, S_RETURN_GAP: begin
                tmr_load = phase_last;
                tmr_val  = HIGH_LOAD;
            end
            default: begin
                tmr_load = 1'b0;
                tmr_val  = HIGH_LOAD;
            end
        endcase
    end

    step_pulse_timer #(
        .CNT_W (TMR_W)
    ) u_timer (
        .clk        (clk),
        .reset      (reset),
        .load       (tmr_load),
        .load_val   (tmr_val),
        .phase_last (phase_last)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg    <= S_IDLE;
            tgt_reg      <= HOME_VAL;
            cur_duty_reg <= HOME_VAL;
            inc_reg      <= 1'b0;
            dec_reg      <= 1'b0;
            done_reg     <= 1'b0;
            ready_reg    <= 1'b1;
            busy_reg     <= 1'b0;
        end else begin
            case (state_reg)
                S_IDLE: begin
                    done_reg <= 1'b0;
                    if (accept) begin
                        tgt_reg   <= req_clamped;
                        ready_reg <= 1'b0;
                        busy_reg  <= 1'b1;
                        if (req_clamped == cur_duty_reg) begin
`ifdef DISPENSE_AUTO_RETURN_EN
                            // The dwell runs even when no movement is needed.
                            state_reg <= S_HOLD;
`else
                            state_reg <= S_FINISH;
                            done_reg  <= 1'b1;
`endif
                        end else begin
                            state_reg <= S_PULSE;
                            inc_reg   <= (req_clamped > cur_duty_reg);
                            dec_reg   <= (req_clamped < cur_duty_reg);
                        end
                    end
                end

                S_PULSE: begin
                    if (phase_last) begin
                        cur_duty_reg <= stepped(cur_duty_reg, inc_reg, dec_reg);
                        inc_reg      <= 1'b0;
                        dec_reg      <= 1'b0;
                        state_reg    <= S_GAP;
                    end
                end

                S_GAP: begin
                    if (phase_last) begin
                        if (dir_tgt != DIR_NONE) begin
                            state_reg <= S_PULSE;
                            inc_reg   <= (dir_tgt == DIR_UP);
                            dec_reg   <= (dir_tgt == DIR_DOWN);
                        end else begin
`ifdef DISPENSE_AUTO_RETURN_EN
                            state_reg <= S_HOLD;
`else
                            state_reg <= S_FINISH;
                            done_reg  <= 1'b1;
`endif
                        end
                    end
                end

`ifdef DISPENSE_AUTO_RETURN_EN
                S_HOLD: begin
                    if (phase_last) begin
                        if (dir_home != DIR_NONE) begin
                            state_reg <= S_RETURN_PULSE;
                            inc_reg   <= (dir_home == DIR_UP);
                            dec_reg   <= (dir_home == DIR_DOWN);
                        end else begin
                            state_reg <= S_FINISH;
                            done_reg  <= 1'b1;
                        end
                    end
                end

                S_RETURN_PULSE: begin
                    if (phase_last) begin
                        cur_duty_reg <= stepped(cur_duty_reg, inc_reg, dec_reg);
                        inc_reg      <= 1'b0;
                        dec_reg      <= 1'b0;
                        state_reg    <= S_RETURN_GAP;
                    end
                end

                S_RETURN_GAP: begin
                    if (phase_last) begin
                        if (dir_home != DIR_NONE) begin
                            state_reg <= S_RETURN_PULSE;
                            inc_reg   <= (dir_home == DIR_UP);
                            dec_reg   <= (dir_home == DIR_DOWN);
                        end else begin
                            state_reg <= S_FINISH;
                            done_reg  <= 1'b1;
                        end
                    end
                end
`endif

                S_FINISH: begin
                    done_reg  <= 1'b0;
                    busy_reg  <= 1'b0;
                    ready_reg <= 1'b1;
                    state_reg <= S_IDLE;
                end

                default: begin
                    state_reg <= S_IDLE;
                    inc_reg   <= 1'b0;
                    dec_reg   <= 1'b0;
                    done_reg  <= 1'b0;
                    busy_reg  <= 1'b0;
                    ready_reg <= 1'b1;
                end
            endcase
        end
    end

    assign req_ready     = ready_reg;
    assign increase_duty = inc_reg;
    assign decrease_duty = dec_reg;
    assign cur_duty      = cur_duty_reg;
    assign busy          = busy_reg;
    assign done          = done_reg;

endmodule

// File: tb/tb_duty_step_sequencer.sv
// ---------------------------------------------------------------------------
// tb_duty_step_sequencer
// Directed bench for duty_step_sequencer. A negedge monitor measures pulse
// widths, gaps, pulse counts, done pulses and shadow-duty steps; each test
// task compares those against hand-computed values.
// Latency is counted in clock edges from the accept edge to the edge after
// which done is high: steps*(4+4) edges, i.e. done lands in cycle
// 1 + steps*8 + 1 when the accept cycle is cycle 1.
// Build with DISPENSE_AUTO_RETURN_EN defined to exercise the auto-return.
// ---------------------------------------------------------------------------
module tb_duty_step_sequencer;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       req_valid = 1'b0;
    logic [4:0] req_duty = 5'd0;
    logic       req_ready;
    logic       increase_duty;
    logic       decrease_duty;
    logic [4:0] cur_duty;
    logic       busy;
    logic       done;

    int n_pass  = 0;
    int n_total = 0;

    duty_step_sequencer dut (
        .clk           (clk),
        .reset         (reset),
        .req_valid     (req_valid),
        .req_duty      (req_duty),
        .req_ready     (req_ready),
        .increase_duty (increase_duty),
        .decrease_duty (decrease_duty),
        .cur_duty      (cur_duty),
        .busy          (busy),
        .done          (done)
    );

    always #5 clk = ~clk;

    // ---------------- monitor ----------------
    logic       mon_en = 1'b0;
    int         inc_pulses, dec_pulses, bad_len, bad_gap, both_cnt;
    int         done_cnt, cur_changes, bad_step, hi_run, lo_run, kind, last_kind;
    logic [4:0] prev_cur;

    always @(negedge clk) begin
        if (!mon_en) begin
            inc_pulses <= 0; dec_pulses <= 0; bad_len <= 0; bad_gap <= 0;
            both_cnt <= 0; done_cnt <= 0; cur_changes <= 0; bad_step <= 0;
            hi_run <= 0; lo_run <= 0; kind <= 0; last_kind <= 0;
            prev_cur <= cur_duty;
        end else begin
            if (increase_duty && decrease_duty) both_cnt <= both_cnt + 1;
            if (done) done_cnt <= done_cnt + 1;
            if (cur_duty != prev_cur) begin
                cur_changes <= cur_changes + 1;
                if (int'(cur_duty) != int'(prev_cur) + 1 && int'(cur_duty) != int'(prev_cur) - 1)
                    bad_step <= bad_step + 1;
                prev_cur <= cur_duty;
            end
            if (increase_duty || decrease_duty) begin
                if (hi_run == 0 && last_kind != 0 &&
                    last_kind == (increase_duty ? 1 : 2) && lo_run != 4)
                    bad_gap <= bad_gap + 1;
                hi_run <= hi_run + 1;
                kind   <= increase_duty ? 1 : 2;
                lo_run <= 0;
            end else begin
                if (hi_run != 0) begin
                    if (hi_run != 4) bad_len <= bad_len + 1;
                    if (kind == 1) inc_pulses <= inc_pulses + 1;
                    else           dec_pulses <= dec_pulses + 1;
                    last_kind <= kind;
                    hi_run    <= 0;
                end
                lo_run <= lo_run + 1;
            end
        end
    end

    // ---------------- stimulus ----------------
    int   lat;
    logic rdy_done, rdy_next;

    task automatic run_req(input logic [4:0] d, input int noise_at,
                           output int l, output logic rd, output logic rn);
        mon_en = 1'b0;
        @(negedge clk);
        #1;
        mon_en    = 1'b1;
        req_valid = 1'b1;
        req_duty  = d;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        l = 0;
        while (done !== 1'b1 && l < 2000) begin
            if (noise_at > 0 && l == noise_at) begin
                req_valid = 1'b1;
                req_duty  = 5'd20;
            end
            if (noise_at > 0 && l == noise_at + 3) req_valid = 1'b0;
            @(posedge clk);
            #1;
            l++;
        end
        req_valid = 1'b0;
        rd = req_ready;
        @(posedge clk);
        #1;
        rn = req_ready;
        @(negedge clk);
        #1;
        $display("req %0d: done after %0d edges, cur_duty=%0d inc=%0d dec=%0d done_pulses=%0d",
                 d, l, cur_duty, inc_pulses, dec_pulses, done_cnt);
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        n_total++; if (cur_duty !== 5'd5) $display("FAIL rst_cur: got %0d expected 5", cur_duty); else n_pass++;
        n_total++; if (req_ready !== 1'b1) $display("FAIL rst_ready: got %0b expected 1", req_ready); else n_pass++;
        n_total++; if ({increase_duty, decrease_duty} !== 2'b00) $display("FAIL rst_pulses: got %b expected 00", {increase_duty, decrease_duty}); else n_pass++;
        n_total++; if ({busy, done} !== 2'b00) $display("FAIL rst_busy_done: got %b expected 00", {busy, done}); else n_pass++;
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1;
        n_total++; if (cur_duty !== 5'd5 || req_ready !== 1'b1 || busy !== 1'b0) $display("FAIL post_rst_idle: got cur=%0d ready=%0b busy=%0b expected 5 1 0", cur_duty, req_ready, busy); else n_pass++;
    endtask

    task automatic test_step_up();
        run_req(5'd8, 0, lat, rdy_done, rdy_next);
        n_total++; if (lat !== 24) $display("FAIL up_latency: got %0d expected 24", lat); else n_pass++;
        n_total++; if (inc_pulses !== 3) $display("FAIL up_inc_pulses: got %0d expected 3", inc_pulses); else n_pass++;
        n_total++; if (dec_pulses !== 0) $display("FAIL up_dec_pulses: got %0d expected 0", dec_pulses); else n_pass++;
        n_total++; if (bad_len !== 0 || bad_gap !== 0) $display("FAIL up_timing: got bad_len=%0d bad_gap=%0d expected 0 0", bad_len, bad_gap); else n_pass++;
        n_total++; if (cur_changes !== 3 || bad_step !== 0) $display("FAIL up_steps: got changes=%0d bad=%0d expected 3 0", cur_changes, bad_step); else n_pass++;
        n_total++; if (cur_duty !== 5'd8) $display("FAIL up_cur: got %0d expected 8", cur_duty); else n_pass++;
        n_total++; if (done_cnt !== 1) $display("FAIL up_done_count: got %0d expected 1", done_cnt); else n_pass++;
        n_total++; if (rdy_done !== 1'b0 || rdy_next !== 1'b1) $display("FAIL up_ready: got %0b%0b expected 01", rdy_done, rdy_next); else n_pass++;
    endtask

    task automatic test_step_down();
        run_req(5'd5, 0, lat, rdy_done, rdy_next);
        n_total++; if (cur_duty !== 5'd5 || dec_pulses !== 3) $display("FAIL down_home: got cur=%0d dec=%0d expected 5 3", cur_duty, dec_pulses); else n_pass++;
        run_req(5'd2, 0, lat, rdy_done, rdy_next);
        n_total++; if (lat !== 24) $display("FAIL down_latency: got %0d expected 24", lat); else n_pass++;
        n_total++; if (dec_pulses !== 3) $display("FAIL down_dec_pulses: got %0d expected 3", dec_pulses); else n_pass++;
        n_total++; if (inc_pulses !== 0 || both_cnt !== 0) $display("FAIL down_no_inc: got inc=%0d both=%0d expected 0 0", inc_pulses, both_cnt); else n_pass++;
        n_total++; if (bad_len !== 0 || bad_gap !== 0) $display("FAIL down_timing: got bad_len=%0d bad_gap=%0d expected 0 0", bad_len, bad_gap); else n_pass++;
        n_total++; if (cur_duty !== 5'd2 || done_cnt !== 1) $display("FAIL down_end: got cur=%0d done=%0d expected 2 1", cur_duty, done_cnt); else n_pass++;
    endtask

    task automatic test_equal();
        run_req(5'd2, 0, lat, rdy_done, rdy_next);
        n_total++; if (lat !== 0) $display("FAIL eq_latency: got %0d expected 0", lat); else n_pass++;
        n_total++; if (inc_pulses + dec_pulses !== 0) $display("FAIL eq_no_pulses: got %0d expected 0", inc_pulses + dec_pulses); else n_pass++;
        n_total++; if (done_cnt !== 1 || cur_duty !== 5'd2) $display("FAIL eq_done: got done=%0d cur=%0d expected 1 2", done_cnt, cur_duty); else n_pass++;
        n_total++; if (rdy_done !== 1'b0 || rdy_next !== 1'b1) $display("FAIL eq_ready: got %0b%0b expected 01", rdy_done, rdy_next); else n_pass++;
    endtask

    task automatic test_boundaries();
        run_req(5'd0, 0, lat, rdy_done, rdy_next);
        n_total++; if (lat !== 16 || cur_duty !== 5'd0 || dec_pulses !== 2) $display("FAIL to_zero: got lat=%0d cur=%0d dec=%0d expected 16 0 2", lat, cur_duty, dec_pulses); else n_pass++;
        run_req(5'd31, 0, lat, rdy_done, rdy_next);
        n_total++; if (lat !== 248 || cur_duty !== 5'd31 || inc_pulses !== 31) $display("FAIL to_max: got lat=%0d cur=%0d inc=%0d expected 248 31 31", lat, cur_duty, inc_pulses); else n_pass++;
        n_total++; if (bad_step !== 0 || bad_len !== 0 || bad_gap !== 0) $display("FAIL to_max_timing: got step=%0d len=%0d gap=%0d expected 0 0 0", bad_step, bad_len, bad_gap); else n_pass++;
        run_req(5'd31, 0, lat, rdy_done, rdy_next);
        n_total++; if (lat !== 0 || inc_pulses !== 0 || cur_duty !== 5'd31) $display("FAIL at_max_again: got lat=%0d inc=%0d cur=%0d expected 0 0 31", lat, inc_pulses, cur_duty); else n_pass++;
        run_req(5'd5, 0, lat, rdy_done, rdy_next);
        n_total++; if (lat !== 208 || cur_duty !== 5'd5 || dec_pulses !== 26) $display("FAIL max_to_home: got lat=%0d cur=%0d dec=%0d expected 208 5 26", lat, cur_duty, dec_pulses); else n_pass++;
    endtask

    task automatic test_busy_ignore();
        run_req(5'd8, 6, lat, rdy_done, rdy_next);
        n_total++; if (lat !== 24 || inc_pulses !== 3) $display("FAIL busy_ignore_seq: got lat=%0d inc=%0d expected 24 3", lat, inc_pulses); else n_pass++;
        n_total++; if (cur_duty !== 5'd8 || done_cnt !== 1) $display("FAIL busy_ignore_end: got cur=%0d done=%0d expected 8 1", cur_duty, done_cnt); else n_pass++;
        repeat (4) @(posedge clk);
        #1;
        n_total++; if (busy !== 1'b0 || cur_duty !== 5'd8) $display("FAIL busy_ignore_idle: got busy=%0b cur=%0d expected 0 8", busy, cur_duty); else n_pass++;
    endtask

    task automatic test_reset_mid();
        @(negedge clk);
        req_valid = 1'b1;
        req_duty  = 5'd11;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        n_total++; if (increase_duty !== 1'b1 || cur_duty !== 5'd9) $display("FAIL mid_pre_reset: got inc=%0b cur=%0d expected 1 9", increase_duty, cur_duty); else n_pass++;
        reset = 1'b1;
        #1;
        n_total++; if (increase_duty !== 1'b0 || decrease_duty !== 1'b0) $display("FAIL mid_async_drop: got inc=%0b dec=%0b expected 0 0", increase_duty, decrease_duty); else n_pass++;
        n_total++; if (cur_duty !== 5'd5 || req_ready !== 1'b1 || busy !== 1'b0) $display("FAIL mid_reset_state: got cur=%0d ready=%0b busy=%0b expected 5 1 0", cur_duty, req_ready, busy); else n_pass++;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        run_req(5'd7, 0, lat, rdy_done, rdy_next);
        n_total++; if (lat !== 16 || inc_pulses !== 2 || cur_duty !== 5'd7) $display("FAIL after_reset_req: got lat=%0d inc=%0d cur=%0d expected 16 2 7", lat, inc_pulses, cur_duty); else n_pass++;
    endtask

    task automatic test_auto_return();
        run_req(5'd7, 0, lat, rdy_done, rdy_next);
        n_total++; if (lat !== 48) $display("FAIL ret_latency: got %0d expected 48", lat); else n_pass++;
        n_total++; if (inc_pulses !== 2 || dec_pulses !== 2) $display("FAIL ret_pulses: got inc=%0d dec=%0d expected 2 2", inc_pulses, dec_pulses); else n_pass++;
        n_total++; if (bad_len !== 0 || bad_gap !== 0 || both_cnt !== 0) $display("FAIL ret_timing: got len=%0d gap=%0d both=%0d expected 0 0 0", bad_len, bad_gap, both_cnt); else n_pass++;
        n_total++; if (cur_duty !== 5'd5 || done_cnt !== 1) $display("FAIL ret_end: got cur=%0d done=%0d expected 5 1", cur_duty, done_cnt); else n_pass++;
        run_req(5'd5, 0, lat, rdy_done, rdy_next);
        n_total++; if (lat !== 16 || inc_pulses + dec_pulses !== 0) $display("FAIL ret_home_hold: got lat=%0d pulses=%0d expected 16 0", lat, inc_pulses + dec_pulses); else n_pass++;
    endtask

    initial begin
        test_reset();
`ifdef DISPENSE_AUTO_RETURN_EN
        test_auto_return();
`else
        test_step_up();
        test_step_down();
        test_equal();
        test_boundaries();
        test_busy_ignore();
        test_reset_mid();
`endif
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
